// File: rtl/fifo_wr_arbiter_pkg.sv
// ============================================================================
// Module      : fifo_wr_arbiter_pkg
// Description : Shared state encoding and default widths for the FIFO write
//               arbiter and the FIFO wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_wr_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int C_DEF_NREQ  = 4;
  localparam int C_DEF_WIDTH = 8;
  localparam int C_DEF_BURST = 4;

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating priority encoder; returns the first set
//               request at or after start, wrapping cyclically.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          hit,
  output logic [IW-1:0] idx
);

  localparam logic [IW:0] C_N = (IW+1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW:0]    w_sum;

  // Rotating the doubled vector puts index 'start' at bit 0.
  assign w_dbl = {req, req} >> start;
  assign w_rot = w_dbl[N-1:0];

  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    w_sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        hit   = 1'b1;
        w_sum = {1'b0, start} + (IW+1)'(k);
        idx   = (w_sum >= C_N) ? IW'(w_sum - C_N) : IW'(w_sum);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter sharing the async FIFO write port among
//               NREQ producers, with bounded bursts and full gating.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int NREQ  = C_DEF_NREQ,
  parameter  int WIDTH = C_DEF_WIDTH,
  parameter  int BURST = C_DEF_BURST,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  input  logic                  full,
  output logic                  signal_write,
  output logic [WIDTH-1:0]      write_data,
  output logic                  busy,
  output logic [IDW-1:0]        owner
);

  localparam int             CW      = $clog2(BURST + 1);
  localparam logic [CW-1:0]  C_BURST = CW'(BURST);
  localparam logic [IDW-1:0] C_LAST  = IDW'(NREQ - 1);

  function automatic logic [IDW-1:0] f_next_idx(input logic [IDW-1:0] idx);
    return (idx == C_LAST) ? '0 : idx + 1'b1;
  endfunction

  arb_state_e     r_state,  w_state_nxt;
  logic [IDW-1:0] r_rr_ptr, w_rr_nxt;
  logic [IDW-1:0] r_owner,  w_owner_nxt;
  logic [CW-1:0]  r_cnt,    w_cnt_nxt;
  logic [NREQ-1:0] w_gnt;
  logic            w_pick_hit;
  logic [IDW-1:0]  w_pick_idx;

  rr_pick #(
    .N (NREQ)
  ) u_pick (
    .req   (req),
    .start (r_rr_ptr),
    .hit   (w_pick_hit),
    .idx   (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_owner  <= w_owner_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Grants are same-cycle so a full FIFO can never be overrun.
  always_comb begin
    w_gnt       = '0;
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    if (!rst && !full) begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_hit) begin
            w_gnt[w_pick_idx] = 1'b1;
            w_owner_nxt       = w_pick_idx;
            w_cnt_nxt         = CW'(1);
            if (BURST > 1) begin
              w_state_nxt = ST_BURST;
            end else begin
              w_rr_nxt = f_next_idx(w_pick_idx);
            end
          end
        end
        ST_BURST: begin
          if (req[r_owner]) begin
            w_gnt[r_owner] = 1'b1;
            w_cnt_nxt      = r_cnt + 1'b1;
            if (w_cnt_nxt == C_BURST) begin
              w_state_nxt = ST_IDLE;
              w_rr_nxt    = f_next_idx(r_owner);
            end
          end else begin
            w_state_nxt = ST_IDLE;
            w_rr_nxt    = f_next_idx(r_owner);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  logic [WIDTH-1:0] w_slice [NREQ];
  logic [WIDTH-1:0] w_wdata;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_slice[gi] = w_gnt[gi] ? req_data[gi*WIDTH +: WIDTH] : '0;
  end

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_wdata = w_wdata | w_slice[i];
    end
  end

  assign gnt          = w_gnt;
  assign signal_write = |w_gnt;
  assign write_data   = w_wdata;
  assign busy         = (r_state == ST_BURST);
  assign owner        = r_owner;

endmodule

`default_nettype wire
